// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the framed receiver and the 32-bit transmitter.
package uart_pkg;

    localparam int unsigned UART_DATA_WIDTH   = 32;
    localparam int unsigned UART_CLKS_PER_BIT = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input plus a registered previous value
// for falling-edge detection. Every flop resets to 1, which matches an idle-high line.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta  <= 1'b1;
            level <= 1'b1;
            prev  <= 1'b1;
        end else begin
            meta  <= line;
            level <= meta;
            prev  <= level;
        end
    end

    assign fall = prev & ~level;

endmodule

// File: rtl/uart_rx_framed.sv
// Framed UART receiver: start/data (MSB first)/stop, mid-bit sampling, and a
// valid/ack output with frame-error and overrun pulses.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Rx,
    input  logic                  RxAck,
    output logic [DATA_WIDTH-1:0] RxData,
    output logic                  RxValid,
    output logic                  RxBusy,
    output logic                  RxFrameErr,
    output logic                  RxOverrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(DATA_WIDTH - 1);

    if (CLKS_PER_BIT < 4) begin : g_param_check
        $error("uart_rx_framed: CLKS_PER_BIT must be >= 4");
    end

    rx_state_t             state, state_nxt;
    logic [CNT_W-1:0]      clk_cnt, clk_cnt_nxt;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  valid_nxt;
    logic                  frame_err_nxt;
    logic                  overrun_nxt;
    logic                  rx_s;
    logic                  rx_fall;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .line  (Rx),
        .level (rx_s),
        .fall  (rx_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            RxData     <= '0;
            RxValid    <= 1'b0;
            RxBusy     <= 1'b0;
            RxFrameErr <= 1'b0;
            RxOverrun  <= 1'b0;
        end else begin
            state      <= state_nxt;
            clk_cnt    <= clk_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift_reg  <= shift_nxt;
            RxData     <= data_nxt;
            RxValid    <= valid_nxt;
            RxBusy     <= (state_nxt != IDLE);
            RxFrameErr <= frame_err_nxt;
            RxOverrun  <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clk_cnt_nxt   = clk_cnt;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift_reg;
        data_nxt      = RxData;
        valid_nxt     = RxValid;
        frame_err_nxt = 1'b0;
        overrun_nxt   = 1'b0;

        // Ack clears first so a good stop in the same cycle can reload and keep valid high.
        if (RxValid && RxAck) begin
            valid_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (rx_fall) begin
                    state_nxt   = START;
                    clk_cnt_nxt = '0;
                end
            end
            START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    shift_nxt   = {shift_reg[DATA_WIDTH-2:0], rx_s};
                    clk_cnt_nxt = '0;
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == WORD_LAST) begin
                        state_nxt = STOP;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    state_nxt   = IDLE;
                    clk_cnt_nxt = '0;
                    if (!rx_s) begin
                        frame_err_nxt = 1'b1;
                    end else if (!RxValid || RxAck) begin
                        data_nxt  = shift_reg;
                        valid_nxt = 1'b1;
                    end else begin
                        overrun_nxt = 1'b1;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed at DATA_WIDTH=32, CLKS_PER_BIT=16.
module tb_uart_rx_framed;

    localparam int unsigned DW  = 32;
    localparam int unsigned CPB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          Rx;
    logic          RxAck;
    logic [DW-1:0] RxData;
    logic          RxValid;
    logic          RxBusy;
    logic          RxFrameErr;
    logic          RxOverrun;

    int n_cmp = 0;
    int n_err = 0;

    int err_pulses = 0, err_hi = 0;
    int ovr_pulses = 0, ovr_hi = 0;
    logic err_q = 1'b0, ovr_q = 1'b0;
    logic busy_seen = 1'b0;

    uart_rx_framed #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Rx         (Rx),
        .RxAck      (RxAck),
        .RxData     (RxData),
        .RxValid    (RxValid),
        .RxBusy     (RxBusy),
        .RxFrameErr (RxFrameErr),
        .RxOverrun  (RxOverrun)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping: number of rising edges and number of high cycles.
    always @(negedge clk) begin
        if (RxFrameErr) err_hi++;
        if (RxFrameErr && !err_q) err_pulses++;
        err_q = RxFrameErr;
        if (RxOverrun) ovr_hi++;
        if (RxOverrun && !ovr_q) ovr_pulses++;
        ovr_q = RxOverrun;
        if (RxBusy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; drives a whole frame, one bit per CPB clocks.
    task automatic send_frame(input logic [DW-1:0] word, input logic stop_bit);
        Rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = DW - 1; i >= 0; i--) begin
            Rx = word[i];
            repeat (CPB) @(negedge clk);
        end
        Rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic ack_pulse();
        RxAck = 1'b1;
        @(negedge clk);
        RxAck = 1'b0;
    endtask

    // Mid-stop sample lands on the 539th rising edge after the start bit is driven,
    // so ack must be driven at the 538th negedge.
    task automatic ack_at_mid_stop();
        repeat (538) @(negedge clk);
        ack_pulse();
    endtask

    logic [DW-1:0] word_r;

    initial begin
        reset = 1'b1;
        Rx    = 1'b1;
        RxAck = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_data",   RxData, 0);
        check("reset_valid",  RxValid, 0);
        check("reset_busy",   RxBusy, 0);
        check("reset_ferr",   RxFrameErr, 0);
        check("reset_ovr",    RxOverrun, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Good frame
        send_frame(32'hA5C3_0F81, 1'b1);
        check("f1_valid", RxValid, 1);
        check("f1_data",  RxData, 64'hA5C3_0F81);
        check("f1_busy",  RxBusy, 0);
        check("f1_ferr",  err_pulses, 0);
        ack_pulse();
        check("ack_clears_valid", RxValid, 0);
        ack_pulse();
        check("ack_idle_ignored", RxValid, 0);
        check("ack_idle_data",    RxData, 64'hA5C3_0F81);

        // Start glitch
        busy_seen = 1'b0;
        Rx = 1'b0;
        repeat (4) @(negedge clk);
        Rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy_seen", busy_seen, 1);
        check("glitch_busy_now",  RxBusy, 0);
        check("glitch_valid",     RxValid, 0);
        check("glitch_ferr",      err_pulses, 0);
        check("glitch_ovr",       ovr_pulses, 0);

        // Framing error, then line held low (break)
        send_frame(32'h1234_5678, 1'b0);
        repeat (60) @(negedge clk);
        check("ferr_pulses", err_pulses, 1);
        check("ferr_width",  err_hi, 1);
        check("ferr_valid",  RxValid, 0);
        check("break_busy",  RxBusy, 0);
        check("ferr_data",   RxData, 64'hA5C3_0F81);
        Rx = 1'b1;
        repeat (20) @(negedge clk);

        // Overrun: two frames back to back, no ack
        send_frame(32'h0000_0001, 1'b1);
        send_frame(32'hFFFF_FFFF, 1'b1);
        repeat (4) @(negedge clk);
        check("ovr_pulses", ovr_pulses, 1);
        check("ovr_width",  ovr_hi, 1);
        check("ovr_data",   RxData, 64'h0000_0001);
        check("ovr_valid",  RxValid, 1);
        ack_pulse();
        check("ovr_ack_valid", RxValid, 0);

        // Ack coincident with second good stop
        send_frame(32'h0000_0001, 1'b1);
        check("ackstop_first_data", RxData, 64'h0000_0001);
        fork
            send_frame(32'hFFFF_FFFF, 1'b1);
            ack_at_mid_stop();
        join
        check("ackstop_ovr",   ovr_pulses, 1);
        check("ackstop_data",  RxData, 64'hFFFF_FFFF);
        check("ackstop_valid", RxValid, 1);

        // Reset during bit 10
        word_r = 32'hDEAD_BEEF;
        Rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            Rx = word_r[DW-1-i];
            repeat (CPB) @(negedge clk);
        end
        Rx = word_r[DW-11];
        repeat (CPB / 2) @(negedge clk);
        check("midframe_busy", RxBusy, 1);
        reset = 1'b1;
        Rx    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_mid_data",  RxData, 0);
        check("rst_mid_valid", RxValid, 0);
        check("rst_mid_busy",  RxBusy, 0);
        repeat (20) @(negedge clk);
        check("rst_mid_ferr",  err_pulses, 1);
        check("rst_mid_ovr",   ovr_pulses, 1);
        check("rst_mid_idle",  RxBusy, 0);
        send_frame(32'hDEAD_BEEF, 1'b1);
        check("dead_valid", RxValid, 1);
        check("dead_data",  RxData, 64'hDEAD_BEEF);
        check("dead_busy",  RxBusy, 0);
        check("final_ferr", err_pulses, 1);
        check("final_ovr",  ovr_pulses, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
